// File: rtl/srl_delay_line_pkg.sv
// Shared constants and elaboration helpers for the srl_delay_line slice:
// SRL primitive lengths, a constant clog2 and the segment-count helpers.
package srl_delay_line_pkg;

  localparam int unsigned SRL16_LEN = 16;
  localparam int unsigned SRL32_LEN = 32;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Number of full 32-deep segments making up a chain of the given depth.
  function automatic int unsigned n32_segs(input int unsigned depth);
    return depth / SRL32_LEN;
  endfunction

  // 1 when a 16-deep tail segment is needed after the 32-deep segments.
  function automatic int unsigned n16_segs(input int unsigned depth);
    return (depth % SRL32_LEN) / SRL16_LEN;
  endfunction

endpackage

// File: rtl/srl_delay_line_segment.sv
// One SRL segment of LEN (16 or 32) stages, WIDTH bits wide. Storage is
// never reset so each bit column maps onto an SRLC16E/SRLC32E. Exposes the
// addressed tap and the cascade (last stage) output. A non-empty SITE
// places the storage at that site.
module srl_delay_line_segment
  import srl_delay_line_pkg::*;
#(
  parameter int unsigned  LEN   = SRL32_LEN,
  parameter int unsigned  WIDTH = 1,
  parameter string        SITE  = "",
  localparam int unsigned SAW   = clog2(LEN)
) (
  input  logic             clk_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [SAW-1:0]   a_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] cas_o
);

  if (SITE == "") begin : g_free
    (* keep = "true", dont_touch = "true" *)
    logic [WIDTH-1:0] stage_q [LEN];

    // Shift the whole column by one stage on each qualified edge.
    always_ff @(posedge clk_i) begin
      if (shift_i) begin
        stage_q[0] <= d_i;
        for (int unsigned k = 1; k < LEN; k++) stage_q[k] <= stage_q[k-1];
      end
    end

    assign q_o   = stage_q[a_i];
    assign cas_o = stage_q[LEN-1];
  end else begin : g_loc
    (* keep = "true", dont_touch = "true", LOC = SITE *)
    logic [WIDTH-1:0] stage_q [LEN];

    // Shift the whole column by one stage on each qualified edge.
    always_ff @(posedge clk_i) begin
      if (shift_i) begin
        stage_q[0] <= d_i;
        for (int unsigned k = 1; k < LEN; k++) stage_q[k] <= stage_q[k-1];
      end
    end

    assign q_o   = stage_q[a_i];
    assign cas_o = stage_q[LEN-1];
  end

endmodule

// File: rtl/srl_delay_line.sv
// Multi-bit runtime-tappable SRL delay line: N32 cascaded 32-deep segments
// plus an optional 16-deep tail, a saturating fill counter that qualifies
// the selected tap, and FULL once every stage holds post-reset data.
// Optional feature macro: SRL_DELAY_OUTREG_EN registers Q/Q_VALID/FULL
// (loaded on CE, cleared by reset), adding one CE edge of latency.
module srl_delay_line
  import srl_delay_line_pkg::*;
#(
  parameter int unsigned  WIDTH = 1,
  parameter int unsigned  DEPTH = 64,
  parameter string        SITE  = "",
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    A,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  output logic             FULL
);

  localparam int unsigned N32  = n32_segs(DEPTH);
  localparam int unsigned N16  = n16_segs(DEPTH);
  localparam int unsigned NSEG = N32 + N16;
  localparam int unsigned FW   = clog2(DEPTH + 1);

  logic             shift;
  logic [AW-1:0]    a_eff;
  int unsigned      seg_idx;
  logic [WIDTH-1:0] chain [NSEG+1];
  logic [WIDTH-1:0] tap [NSEG];
  logic [WIDTH-1:0] tap_sel;
  logic [FW-1:0]    fill_q, fill_d;
  logic [WIDTH-1:0] q_c;
  logic             q_valid_c;
  logic             full_c;

  // Reset wins over CE: a reset cycle never shifts.
  assign shift    = CE & RST_N;
  assign chain[0] = D;

  assign a_eff   = (32'(A) >= DEPTH) ? AW'(DEPTH - 1) : A;
  assign seg_idx = 32'(a_eff) / SRL32_LEN;

  for (genvar s = 0; s < N32; s++) begin : g_srl32
    srl_delay_line_segment #(
      .LEN   (SRL32_LEN),
      .WIDTH (WIDTH),
      .SITE  (SITE)
    ) u_seg (
      .clk_i   (CLK),
      .shift_i (shift),
      .d_i     (chain[s]),
      .a_i     (a_eff[4:0]),
      .q_o     (tap[s]),
      .cas_o   (chain[s+1])
    );
  end

  // The tail only ever sees taps whose bit 4 is clear, so the low four
  // address bits are sufficient.
  if (N16 != 0) begin : g_srl16
    srl_delay_line_segment #(
      .LEN   (SRL16_LEN),
      .WIDTH (WIDTH),
      .SITE  (SITE)
    ) u_tail (
      .clk_i   (CLK),
      .shift_i (shift),
      .d_i     (chain[N32]),
      .a_i     (a_eff[3:0]),
      .q_o     (tap[N32]),
      .cas_o   (chain[NSEG])
    );
  end

  // Upper tap bits pick which segment drives the output.
  always_comb begin
    tap_sel = '0;
    for (int unsigned s = 0; s < NSEG; s++) begin
      if (seg_idx == s) tap_sel = tap[s];
    end
  end

  // Fill count: cleared by reset, counts shifts, saturates at DEPTH.
  always_comb begin
    fill_d = fill_q;
    if (!RST_N) fill_d = '0;
    else if (CE && (32'(fill_q) < DEPTH)) fill_d = fill_q + FW'(1);
  end

  // Fill counter register.
  always_ff @(posedge CLK) begin
    fill_q <= fill_d;
  end

  assign q_valid_c = 32'(fill_q) > 32'(a_eff);
  assign full_c    = 32'(fill_q) == DEPTH;
  assign q_c       = q_valid_c ? tap_sel : '0;

`ifdef SRL_DELAY_OUTREG_EN
  logic [WIDTH-1:0] q_q;
  logic             q_valid_q;
  logic             full_q;

  // Output register: cleared by reset, follows the tap path on CE edges.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      q_q       <= '0;
      q_valid_q <= 1'b0;
      full_q    <= 1'b0;
    end else if (CE) begin
      q_q       <= q_c;
      q_valid_q <= q_valid_c;
      full_q    <= full_c;
    end
  end

  assign Q       = q_q;
  assign Q_VALID = q_valid_q;
  assign FULL    = full_q;
`else
  assign Q       = q_c;
  assign Q_VALID = q_valid_c;
  assign FULL    = full_c;
`endif

endmodule

// File: tb/tb_srl_delay_line.sv
// Bench for srl_delay_line: a 64-deep (power-of-two, two SRL32 segments)
// and a 48-deep (SRL32 + SRL16 tail, clamp reachable) instance share
// CLK/RST_N/CE/D with independent taps. Expected outputs come from a
// sample-history model; SRL_DELAY_OUTREG_EN selects the registered model.
module tb_srl_delay_line;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic [7:0] d;
  logic [5:0] a64, a48;
  logic [7:0] q64, q48;
  logic       v64, v48, f64, f48;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Model state: newest sample at index 0, shifts since the last reset.
  logic [7:0]  hist[$];
  int unsigned nshift = 0;
  logic [7:0]  rq [2];
  logic        rv [2];
  logic        rf [2];

  always #5 clk = ~clk;

  srl_delay_line #(.WIDTH(8), .DEPTH(64)) u_d64 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .D(d), .A(a64),
    .Q(q64), .Q_VALID(v64), .FULL(f64)
  );

  srl_delay_line #(.WIDTH(8), .DEPTH(48)) u_d48 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .D(d), .A(a48),
    .Q(q48), .Q_VALID(v48), .FULL(f48)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Unregistered view of the model for one tap/depth.
  task automatic model_comb(input int unsigned a, input int unsigned depth,
                            output logic [7:0] q, output logic v, output logic f);
    int unsigned t;
    t = (a >= depth) ? depth - 1 : a;
    v = nshift > t;
    f = nshift >= depth;
    q = v ? hist[t] : 8'h00;
  endtask

  task automatic expected(input int unsigned i, output logic [7:0] q,
                          output logic v, output logic f);
`ifdef SRL_DELAY_OUTREG_EN
    q = rq[i]; v = rv[i]; f = rf[i];
`else
    if (i == 0) model_comb(a64, 64, q, v, f);
    else        model_comb(a48, 48, q, v, f);
`endif
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] eq;
    logic       ev, ef;
    expected(0, eq, ev, ef);
    chk({tag, "_q64"}, 32'(q64), 32'(eq));
    chk({tag, "_v64"}, 32'(v64), 32'(ev));
    chk({tag, "_f64"}, 32'(f64), 32'(ef));
    expected(1, eq, ev, ef);
    chk({tag, "_q48"}, 32'(q48), 32'(eq));
    chk({tag, "_v48"}, 32'(v48), 32'(ev));
    chk({tag, "_f48"}, 32'(f48), 32'(ef));
  endtask

  // One clock: drive inputs, advance the model at the edge, settle 1 time unit.
  task automatic tick(input logic c, input logic rn, input logic [7:0] din);
    logic [7:0] cq;
    logic       cv, cf;
    ce = c; rst_n = rn; d = din;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (i == 0) model_comb(a64, 64, cq, cv, cf);
      else        model_comb(a48, 48, cq, cv, cf);
      if (!rn) begin
        rq[i] = 8'h00; rv[i] = 1'b0; rf[i] = 1'b0;
      end else if (c) begin
        rq[i] = cq; rv[i] = cv; rf[i] = cf;
      end
    end
    if (!rn) nshift = 0;
    else if (c) begin
      hist.push_front(din);
      if (hist.size() > 64) void'(hist.pop_back());
      nshift++;
    end
    #1;
  endtask

  task automatic ramp(input string tag, input int unsigned n, inout int unsigned k);
    for (int unsigned j = 0; j < n; j++) begin
      tick(1'b1, 1'b1, 8'(k));
      k++;
      check_outputs(tag);
    end
  endtask

  initial begin
    int unsigned k;
    rst_n = 1'b0; ce = 1'b0; d = '0; a64 = '0; a48 = '0;
    #2;

    // Single sample through a zero-delay tap.
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    check_outputs("rst");
    tick(1'b1, 1'b1, 8'hA5);
    check_outputs("one");
    tick(1'b0, 1'b1, 8'h3C);
    check_outputs("one_hold");

    // Long ramp: 48-deep tap lives in the tail segment.
    tick(1'b0, 1'b0, 8'h00);
    a64 = 6'd47; a48 = 6'd40;
    k = 1;
    ramp("ramp", 70, k);

    // Same-cycle tap change, then a CE stall mid-stream.
    a64 = 6'd20; a48 = 6'd20;
    #1;
    check_outputs("tapchg");
    ramp("pre_stall", 5, k);
    for (int j = 0; j < 10; j++) begin
      tick(1'b0, 1'b1, 8'($urandom));
      check_outputs("stall");
    end
    ramp("resume", 10, k);

    // Maximum tap: 48-deep instance clamps 63 to 47.
    tick(1'b1, 1'b0, 8'h00);
    a64 = 6'd63; a48 = 6'd63;
    k = 100;
    ramp("clamp", 66, k);

    // Reset after FULL with CE high; refill through a short tap.
    a64 = 6'd5; a48 = 6'd5;
    tick(1'b1, 1'b0, 8'hEE);
    check_outputs("rst_mid");
    ramp("refill", 8, k);

    // Random traffic with occasional resets and tap changes.
    for (int j = 0; j < 300; j++) begin
      if ($urandom_range(0, 9) == 0) a64 = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a48 = 6'($urandom_range(0, 63));
      tick(($urandom_range(0, 9) < 7), ($urandom_range(0, 99) >= 3), 8'($urandom));
      check_outputs("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
